// File: rtl/intr_pkg.sv
// intr_pkg: shared definitions for the interrupt controller.
//   - Register address map for the 4-bit io_addr bus.
//   - CLAIM read-word field positions and a helper that packs the word.
package intr_pkg;

  localparam logic [3:0] AddrPending  = 4'd0;
  localparam logic [3:0] AddrStatus   = 4'd1;
  localparam logic [3:0] AddrEnable   = 4'd2;
  localparam logic [3:0] AddrMode     = 4'd3;
  localparam logic [3:0] AddrSet      = 4'd4;
  localparam logic [3:0] AddrClr      = 4'd5;
  localparam logic [3:0] AddrClaim    = 4'd6;
  localparam logic [3:0] AddrTctrl    = 4'd7;
  localparam logic [3:0] AddrTcountLo = 4'd8;
  localparam logic [3:0] AddrTcountHi = 4'd9;
  localparam logic [3:0] AddrTreloadLo = 4'd10;
  localparam logic [3:0] AddrTreloadHi = 4'd11;

  // CLAIM read word: valid flag in bit 15, source index in the low nibble.
  localparam int unsigned ClaimValidBit = 15;
  localparam int unsigned ClaimIdxLsb   = 0;
  localparam int unsigned ClaimIdxW     = 4;

  function automatic logic [15:0] claim_word(input logic valid,
                                             input logic [ClaimIdxW-1:0] idx);
    logic [15:0] w;
    w = '0;
    if (valid) begin
      w[ClaimValidBit]                  = 1'b1;
      w[ClaimIdxLsb +: ClaimIdxW]       = idx;
    end
    return w;
  endfunction

endpackage

// File: rtl/intr_timer.sv
// intr_timer: reloading down-counter that raises the internal event (source 0).
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   write, addr, wdata - register bus shared with the controller
//   fire         - one-cycle event when a running counter reaches zero
//   rdata        - read data for TCTRL/TCOUNT/TRELOAD, 0 for other addresses
module intr_timer
  import intr_pkg::*;
#(
  parameter int unsigned TW = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic [3:0]  addr,
  input  logic [15:0] wdata,
  output logic        fire,
  output logic [15:0] rdata
);

  logic          run_q, run_d, oneshot_q, oneshot_d;
  logic [TW-1:0] count_q, count_d, reload_q, reload_d;
  logic [31:0]   count_ext, reload_ext;
  logic          wr_ctrl, wr_cnt_lo, wr_cnt_hi, wr_rld_lo, wr_rld_hi, hold;

  assign wr_ctrl   = write && (addr == AddrTctrl);
  assign wr_cnt_lo = write && (addr == AddrTcountLo);
  assign wr_cnt_hi = write && (addr == AddrTcountHi);
  assign wr_rld_lo = write && (addr == AddrTreloadLo);
  assign wr_rld_hi = write && (addr == AddrTreloadHi);
  // Any count/reload write freezes the timer for that cycle.
  assign hold      = wr_cnt_lo | wr_cnt_hi | wr_rld_lo | wr_rld_hi;

  assign fire = run_q && (count_q == '0) && !hold && !reset;

  always_comb begin
    run_d     = run_q;
    oneshot_d = oneshot_q;
    count_d   = count_q;
    reload_d  = reload_q;
    if (hold) begin
      if (wr_cnt_lo) count_d[15:0]     = wdata;
      if (wr_cnt_hi) count_d[TW-1:16]  = wdata[TW-17:0];
      if (wr_rld_lo) reload_d[15:0]    = wdata;
      if (wr_rld_hi) reload_d[TW-1:16] = wdata[TW-17:0];
    end else if (run_q) begin
      if (count_q == '0) begin
        count_d = reload_q;
        if (oneshot_q) run_d = 1'b0;
      end else begin
        count_d = count_q - TW'(1);
      end
    end
    if (wr_ctrl) begin
      run_d     = wdata[0];
      oneshot_d = wdata[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q     <= 1'b0;
      oneshot_q <= 1'b0;
      count_q   <= '0;
      reload_q  <= '0;
    end else begin
      run_q     <= run_d;
      oneshot_q <= oneshot_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
    end
  end

  // Zero-extend to 32 bits so the hi halves read back zero-padded for any TW.
  assign count_ext  = 32'(count_q);
  assign reload_ext = 32'(reload_q);

  always_comb begin
    rdata = '0;
    case (addr)
      AddrTctrl:     rdata = {14'b0, oneshot_q, run_q};
      AddrTcountLo:  rdata = count_ext[15:0];
      AddrTcountHi:  rdata = count_ext[31:16];
      AddrTreloadLo: rdata = reload_ext[15:0];
      AddrTreloadHi: rdata = reload_ext[31:16];
      default:       rdata = '0;
    endcase
  end

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl: interrupt controller with NEXT external sources plus an internal
// timer event on index 0. Sources are level or rising-edge (latched) per MODE.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   src         - external requests, src[i] is source index i+1
//   interrupt   - registered OR of PENDING
//   io_write, io_addr, io_wdata - register write bus
//   io_rdata    - combinational read data, unused bits 0
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int unsigned NEXT = 7,
  parameter int unsigned TW   = 24
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NEXT-1:0] src,
  output logic            interrupt,
  input  logic            io_write,
  input  logic [3:0]      io_addr,
  input  logic [15:0]     io_wdata,
  output logic [15:0]     io_rdata
);

  localparam int unsigned N = NEXT + 1;

  logic [NEXT-1:0] src_q;
  logic [N-1:0]    enable_q, mode_q, latch_q, latch_d;
  logic [N-1:0]    status, pending, set_ev, clr_ev, claim_clr;
  logic            irq_q, fire, wr_set, wr_clr, wr_claim, claim_valid;
  logic [3:0]      claim_idx;
  logic [15:0]     timer_rdata;

  intr_timer #(
    .TW(TW)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .write (io_write),
    .addr  (io_addr),
    .wdata (io_wdata),
    .fire  (fire),
    .rdata (timer_rdata)
  );

  assign wr_set   = io_write && (io_addr == AddrSet);
  assign wr_clr   = io_write && (io_addr == AddrClr);
  assign wr_claim = io_write && (io_addr == AddrClaim);

  // mode_q[0] is held at 1, so the timer source always uses its latch.
  assign status  = (mode_q & latch_q) | (~mode_q & {src, 1'b0});
  assign pending = enable_q & status;

  always_comb begin
    claim_clr = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (wr_claim && (io_wdata[3:0] == 4'(i))) claim_clr[i] = 1'b1;
    end
    set_ev = {src & ~src_q, fire};
    if (wr_set) set_ev = set_ev | (io_wdata[N-1:0] & mode_q);
    clr_ev = claim_clr & mode_q;
    if (wr_clr) clr_ev = clr_ev | (io_wdata[N-1:0] & mode_q);
    // Set wins over a simultaneous clear.
    latch_d = (latch_q & ~clr_ev) | set_ev;
  end

  // Lowest index has highest priority: scan downward so the last hit wins.
  always_comb begin
    claim_valid = |pending;
    claim_idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (pending[i]) claim_idx = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q    <= '0;
      enable_q <= '0;
      mode_q   <= {{(N-1){1'b0}}, 1'b1};
      latch_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      src_q   <= src;
      latch_q <= latch_d;
      irq_q   <= |pending;
      if (io_write && (io_addr == AddrEnable)) enable_q <= io_wdata[N-1:0];
      if (io_write && (io_addr == AddrMode))   mode_q   <= {io_wdata[N-1:1], 1'b1};
    end
  end

  assign interrupt = irq_q;

  always_comb begin
    io_rdata = '0;
    case (io_addr)
      AddrPending:   io_rdata = 16'(pending);
      AddrStatus:    io_rdata = 16'(status);
      AddrEnable:    io_rdata = 16'(enable_q);
      AddrMode:      io_rdata = 16'(mode_q);
      AddrClaim:     io_rdata = claim_word(claim_valid, claim_idx);
      AddrTctrl,
      AddrTcountLo,
      AddrTcountHi,
      AddrTreloadLo,
      AddrTreloadHi: io_rdata = timer_rdata;
      default:       io_rdata = '0;
    endcase
  end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have parameter NEXT, default 7, number of external sources (1..15).
REQ-002 SHALL have parameter TW, default 24, timer width (17..32).
REQ-003 SHALL have port clk, input, 1, sole clock.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port src, input, NEXT, external requests, synchronous to clk; src[i] maps to source index i+1.
REQ-006 SHALL have port interrupt, output, 1, registered OR of PENDING.
REQ-007 SHALL have port io_write, input, 1, register write strobe.
REQ-008 SHALL have port io_addr, input, 4, register index.
REQ-009 SHALL have port io_wdata, input, 16, write data.
REQ-010 SHALL have port io_rdata, output, 16, combinational read data; unused bits 0.

Function
REQ-011 SHALL support N=NEXT+1 sources; index 0 SHALL be the internal timer event (always edge mode).
REQ-012 SHALL use this register map: 0 PENDING ro; 1 STATUS ro; 2 ENABLE rw; 3 MODE rw (1=rising edge, 0=level; bit0 reads 1); 4 SET w1s; 5 CLR w1c; 6 CLAIM; 7 TCTRL (bit0 run, bit1 oneshot); 8/9 TCOUNT lo/hi; 10/11 TRELOAD lo/hi. Other addresses SHALL read 0 and ignore writes.
REQ-013 STATUS[i] SHALL be src live in level mode, else the edge latch.
REQ-014 An edge latch SHALL set when src goes 0->1 versus previous-cycle sample, or on SET bit i; it SHALL clear on CLR bit i or CLAIM write of index i.
REQ-015 A set event and a clear event to the same latch in one cycle SHALL leave it set.
REQ-016 SET/CLR on level-mode bits SHALL have no effect; switching MODE SHALL not clear the latch.
REQ-017 PENDING SHALL equal ENABLE & STATUS; interrupt SHALL equal |PENDING delayed one clk.
REQ-018 CLAIM read SHALL return bit15=1 and bits[3:0]=lowest pending index if any pending, else 0; lowest index SHALL be highest priority.
REQ-019 CLAIM write SHALL clear edge latch io_wdata[3:0]; out-of-range or level-mode index SHALL be ignored.
REQ-020 Timer, when run=1: count==0 SHALL fire event 0 and load TRELOAD; else SHALL decrement by 1 per clk.
REQ-021 On fire with oneshot=1, run SHALL clear in the same cycle; reload SHALL still occur.
REQ-022 When run=0, count SHALL hold and no event SHALL fire.
REQ-023 TCOUNT/TRELOAD writes SHALL update only the addressed half (hi uses io_wdata[TW-17:0]) and SHALL take priority over decrement/reload that cycle, with no event fired.
REQ-024 TCOUNT/TRELOAD hi reads SHALL zero-extend to 16 bits.

Reset
REQ-025 Reset SHALL zero ENABLE, MODE (bit0 reads 1), edge latches, src samples, TCTRL, TCOUNT, TRELOAD, and interrupt.
REQ-026 Reset mid-count SHALL abort the timer with no event fired that cycle.

Structure
REQ-027 Register address constants and CLAIM field positions SHALL live in package intr_pkg.
REQ-028 Timer SHALL be sub-module intr_timer (parameter TW), exposing fire and register ports.
REQ-029 Implementation SHALL be fully synchronous with no latches.

Verification
REQ-030 NEXT=7: MODE=0x0004, ENABLE=0x0004, pulse src[1] one clk -> PENDING=0x0004, interrupt 1 next cycle, stays 1 after src drops; CLAIM read=0x8002; CLAIM write 2 -> PENDING=0.
REQ-031 Level src[0] high, ENABLE=0x0002, MODE=0 -> interrupt high; src low -> interrupt low one cycle later; SET 0x0002 has no effect.
REQ-032 SET=0x0006 with ENABLE=0x0006 -> CLAIM=0x8001; CLR 0x0002 -> CLAIM=0x8002.
REQ-033 TRELOAD=3, TCOUNT=3, TCTRL=1 -> event 0 every 4 clks; with TCTRL=3 -> one event, then run=0, TCOUNT=3.
REQ-034 Rising edge on src[2] in same cycle as CLR bit3 -> latch set; reset asserted mid-count -> all registers 0, interrupt 0.
